// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sap_pkg
//  Purpose  : Shared encodings for the RAM port-B arbiter (FSM states,
//             owner codes, read latency) plus a state-to-owner helper.
//  Revision : 1.0 - initial release
// ============================================================================
package sap_pkg;

  // Arbiter FSM states
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_LOCK0 = 2'd1;
  localparam logic [1:0] ARB_LOCK1 = 2'd2;

  // Values presented on the owner output
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_R0   = 2'b01;
  localparam logic [1:0] OWNER_R1   = 2'b10;

  // The RAM registers its read data, so read data arrives one cycle after grant
  localparam int RD_LATENCY = 1;

  // Map a registered FSM state onto the owner code
  function automatic logic [1:0] owner_of(input logic [1:0] state);
    logic [1:0] code;
    case (state)
      ARB_LOCK0: code = OWNER_R0;
      ARB_LOCK1: code = OWNER_R1;
      default:   code = OWNER_NONE;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Two-way request picker. Round-robin against the last winner,
//             or fixed priority to requester 0 when i_fixed is set.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_fixed,
  output logic [1:0] o_gnt,
  output logic       o_winner
);

  // One-hot pick; on contention favour the requester that did not win last
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      if (i_fixed || i_last) begin
        o_gnt = 2'b01;
      end else begin
        o_gnt = 2'b10;
      end
    end
    o_winner = o_gnt[1];
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares the single data port of the 256x8 RAM between the CPU
//             load/store path (r0) and a loader/debug master (r1). Supports
//             multi-beat locked ownership and returns registered read valid
//             one cycle after a read grant.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import sap_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int PRIO_FIXED = 0
) (
  input  logic          clk,
  input  logic          reset,
  // requester 0
  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  // requester 1
  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  // RAM port B
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out,
  // ownership status
  output logic [1:0]    owner
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last;
  logic       r_rp_valid;
  logic       r_rp_id;

  logic [1:0] w_pick_gnt;
  logic       w_pick_win;
  logic [1:0] w_gnt;
  logic       w_win;

  rr_pick2 u_pick (
    .i_req    ({r1_req, r0_req}),
    .i_last   (r_last),
    .i_fixed  (PRIO_FIXED != 0),
    .o_gnt    (w_pick_gnt),
    .o_winner (w_pick_win)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: enter a lock on a locked grant, leave on any lock=0 cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt[0] && r0_lock) begin
          w_state_nxt = ARB_LOCK0;
        end else if (w_gnt[1] && r1_lock) begin
          w_state_nxt = ARB_LOCK1;
        end
      end
      ARB_LOCK0: if (!r0_lock) w_state_nxt = ARB_IDLE;
      ARB_LOCK1: if (!r1_lock) w_state_nxt = ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // FSM outputs: grants (lock owner only, picker when idle) and RAM port mux
  always_comb begin
    w_gnt    = 2'b00;
    w_win    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_in   = '0;
    if (!reset) begin
      case (r_state)
        ARB_IDLE: begin
          w_gnt = w_pick_gnt;
          w_win = w_pick_win;
        end
        ARB_LOCK0: begin
          w_gnt = {1'b0, r0_req};
          w_win = 1'b0;
        end
        ARB_LOCK1: begin
          w_gnt = {r1_req, 1'b0};
          w_win = 1'b1;
        end
        default: begin
          w_gnt = 2'b00;
          w_win = 1'b0;
        end
      endcase
    end
    if (w_gnt[0]) begin
      mem_we   = r0_we;
      mem_addr = r0_addr;
      mem_in   = r0_wdata;
    end else if (w_gnt[1]) begin
      mem_we   = r1_we;
      mem_addr = r1_addr;
      mem_in   = r1_wdata;
    end
  end

  // Round-robin pointer and the one-deep read-pending tag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last     <= 1'b1;
      r_rp_valid <= 1'b0;
      r_rp_id    <= 1'b0;
    end else begin
      if (|w_gnt) begin
        r_last <= w_win;
      end
      r_rp_valid <= (|w_gnt) & ~mem_we;
      r_rp_id    <= w_win;
    end
  end

  assign r0_gnt = w_gnt[0];
  assign r1_gnt = w_gnt[1];

  // A read tag still in flight when reset rises must never surface
  assign r0_rvalid = r_rp_valid & ~r_rp_id & ~reset;
  assign r1_rvalid = r_rp_valid &  r_rp_id & ~reset;
  assign r0_rdata  = mem_out;
  assign r1_rdata  = mem_out;

  assign owner = reset ? OWNER_NONE : owner_of(r_state);

endmodule
`default_nettype wire
